fb_frame_sequencer: RTL
=======================

Name: fb_frame_sequencer

Overview:
- Sequences the double-buffered framebuffer pair each frame: clear back buffer -> arbitrate two pixel writers -> swap on vsync.
- Drives the two write ports (addr_wr1/2, data_wr1/2, wr1/2_en) and the read_pick buffer select of the framebuffer pair.
- Swaps only when the back buffer is complete; otherwise holds the front buffer and counts a dropped frame.
- Replaces the free-running vsync divider as the owner of read_pick.

Parameters:
- FB_SIZE, 307200, pixel count per buffer (640x480); must be even.
- ADDR_W, 19, framebuffer address width.
- CLEAR_COLOR, 4'h0, palette index written during clear.

Ports:
- clock  in  1  system clock (write-side clock of the framebuffer pair).
- reset  in  1  synchronous, active-low reset.
- vsync  in  1  display vsync, already synchronous to clock.
- req0_valid  in  1  writer 0 has a pixel.
- req0_addr  in  ADDR_W  writer 0 pixel address.
- req0_data  in  4  writer 0 colour index.
- req0_ready  out  1  writer 0 pixel accepted this cycle (combinational).
- req0_done  in  1  writer 0 finished frame (pulse or level).
- req1_valid, req1_addr, req1_data, req1_ready, req1_done  same as writer 0, for writer 1.
- addr_wr1 / addr_wr2  out  ADDR_W  framebuffer write addresses, registered.
- data_wr1 / data_wr2  out  4  write data, registered.
- wr1_en / wr2_en  out  1  write enables, registered.
- read_pick  out  1  front-buffer select; 0 = fb0 displayed, fb1 written.
- frame_start  out  1  one-cycle pulse when DRAW is entered.
- swap  out  1  one-cycle pulse in the cycle read_pick toggles.
- drop_count  out  8  saturating count of vsync falling edges with no swap.

Behaviour:
- Reset (reset=0 at posedge): read_pick=0, all wr*_en=0, addr/data=0, swap=0, frame_start=0, drop_count=0, clear pointer=0, done flags cleared, rr_ptr=0, state=CLEAR.
- Reset mid-operation aborts any clear or draw. After release, clearing restarts at address 0.
- Vsync falling edge (fall): prior-cycle vsync=1 and current vsync=0. The edge register resets to 0.
- CLEAR:
  - Each cycle: wr1_en=1, addr_wr1=ptr, data_wr1=CLEAR_COLOR; wr2_en=1, addr_wr2=ptr+1, data_wr2=CLEAR_COLOR.
  - ptr += 2 per cycle. Clear takes exactly FB_SIZE/2 cycles.
  - req*_ready=0 throughout.
  - After the last pair (ptr=FB_SIZE-2) -> DRAW; frame_start pulses on the first DRAW cycle.
- DRAW, default: writer 0 -> port 1, writer 1 -> port 2. ready = valid, subject to the two rules below.
  - Conflict (both valid, addresses equal): grant only the writer selected by rr_ptr (0 = writer 0), then toggle rr_ptr. The losing writer's ready=0 and it retries next cycle.
  - Out-of-range address (>= FB_SIZE): ready=1, pixel discarded, no write.
  - Latency: handshake accepted in cycle n -> wr_en/addr/data on the port in cycle n+1. wr_en=0 on a port with no grant.
  - done0/done1 are sticky flags, set by req*_done.
  - Both flags set -> DONE on the next cycle. A pixel handshaken in the same cycle is still written, one cycle later.
- DONE: ready=0, wr_en=0; waits for fall.
- On fall:
  - In DONE: toggle read_pick, swap=1, clear done flags, reset clear pointer -> CLEAR.
  - In CLEAR or DRAW: no swap; drop_count += 1, saturating at 255.
  - fall and the DRAW->DONE transition in the same cycle: counts as a drop. The swap waits for the next fall.
- Buffer mapping is fixed by read_pick. The sequencer only addresses the back buffer, and the pair routes by read_pick. read_pick changes only with swap, so no write straddles a swap.

Test Plan:
- Reset/clear, FB_SIZE=16:
  - Hold reset=0 two cycles, release -> 8 cycles of wr1_en=wr2_en=1 with (addr_wr1,addr_wr2) = (0,1),(2,3)...(14,15), data=0.
  - frame_start pulses in cycle 9; read_pick=0.
- Draw with latency:
  - req0 (addr 5, data 4'hA) and req1 (addr 6, data 4'h3) valid in cycle n -> both ready=1.
  - Cycle n+1: wr1_en=1 addr 5 data A, wr2_en=1 addr 6 data 3.
- Conflict round-robin: both writers at addr 7 for 3 consecutive cycles -> grants go writer0, writer1, writer0; exactly one wr_en per cycle.
- Normal swap: assert req0_done then req1_done, then vsync 1->0 -> swap=1 for one cycle, read_pick=1, CLEAR restarts at addr 0.
- Dropped frame: vsync fall during CLEAR and twice more during DRAW -> drop_count=3, read_pick unchanged. After done and the next fall -> swap.
- Edge cases:
  - 300 drops -> drop_count=255.
  - req0_addr=16 with FB_SIZE=16 -> ready=1, no wr1_en.
  - reset=0 mid-DRAW -> outputs at reset values; clear restarts at 0.

Source files
------------

// File: rtl/fb_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// fb_frame_sequencer_if
// Bundles the sequencer's non-clock signals:
//   - vsync from the display timing,
//   - two pixel-writer request channels (valid/addr/data/ready/done),
//   - the two framebuffer write ports,
//   - the front-buffer select, frame/swap pulses and the dropped-frame count.
// Modports:
//   master : the sequencer (drives write ports, ready, read_pick, status)
//   slave  : the environment (writers, display timing, framebuffer pair)
// -----------------------------------------------------------------------------
interface fb_frame_sequencer_if #(
    parameter int ADDR_W = 19
);
    logic              vsync;

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [3:0]        req0_data;
    logic              req0_ready;
    logic              req0_done;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [3:0]        req1_data;
    logic              req1_ready;
    logic              req1_done;

    logic [ADDR_W-1:0] addr_wr1;
    logic [ADDR_W-1:0] addr_wr2;
    logic [3:0]        data_wr1;
    logic [3:0]        data_wr2;
    logic              wr1_en;
    logic              wr2_en;

    logic              read_pick;
    logic              frame_start;
    logic              swap;
    logic [7:0]        drop_count;

    modport master (
        input  vsync,
        input  req0_valid, req0_addr, req0_data, req0_done,
        input  req1_valid, req1_addr, req1_data, req1_done,
        output req0_ready, req1_ready,
        output addr_wr1, addr_wr2, data_wr1, data_wr2, wr1_en, wr2_en,
        output read_pick, frame_start, swap, drop_count
    );

    modport slave (
        output vsync,
        output req0_valid, req0_addr, req0_data, req0_done,
        output req1_valid, req1_addr, req1_data, req1_done,
        input  req0_ready, req1_ready,
        input  addr_wr1, addr_wr2, data_wr1, data_wr2, wr1_en, wr2_en,
        input  read_pick, frame_start, swap, drop_count
    );
endinterface

// File: rtl/fb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fb_frame_sequencer
// Per-frame control of a double-buffered framebuffer pair:
//   CLEAR : fills the back buffer with CLEAR_COLOR, two pixels per cycle
//   DRAW  : arbitrates two pixel writers onto the two write ports
//   DONE  : waits for the vsync falling edge, then swaps buffers
// A vsync falling edge outside DONE leaves the front buffer alone and bumps a
// saturating dropped-frame counter.
// Ports:
//   clock  : system clock (write-side clock of the framebuffer pair)
//   reset  : synchronous, active-low
//   bus    : fb_frame_sequencer_if.master (vsync, writer channels, write
//            ports, read_pick, frame_start, swap, drop_count)
// -----------------------------------------------------------------------------
module fb_frame_sequencer #(
    parameter int unsigned FB_SIZE     = 307200,
    parameter int          ADDR_W      = 19,
    parameter logic [3:0]  CLEAR_COLOR = 4'h0
) (
    input  logic                clock,
    input  logic                reset,
    fb_frame_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        DRAW  = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The clear pointer is one bit wider than an address so it can reach
    // FB_SIZE itself, which marks "every pair has been issued".
    localparam logic [ADDR_W:0] FB_END   = (ADDR_W + 1)'(FB_SIZE);
    localparam logic [ADDR_W:0] PTR_STEP = (ADDR_W + 1)'(2);

    state_t          state;
    logic [ADDR_W:0] ptr;
    logic            done0;
    logic            done1;
    logic            rr_ptr;
    logic            vsync_q;

    logic            fall;
    logic            conflict;
    logic            grant0;
    logic            grant1;
    logic            write0;
    logic            write1;
    logic            both_done;

    always_comb begin
        fall      = vsync_q & ~bus.vsync;
        conflict  = bus.req0_valid & bus.req1_valid & (bus.req0_addr == bus.req1_addr);
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (state == DRAW) begin
            // On an address collision only the round-robin winner is taken.
            grant0 = bus.req0_valid & (~conflict | ~rr_ptr);
            grant1 = bus.req1_valid & (~conflict |  rr_ptr);
        end
        // Out-of-range pixels are acknowledged but never reach a port.
        write0    = grant0 & ({1'b0, bus.req0_addr} < FB_END);
        write1    = grant1 & ({1'b0, bus.req1_addr} < FB_END);
        both_done = (done0 | bus.req0_done) & (done1 | bus.req1_done);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= CLEAR;
            ptr             <= '0;
            done0           <= 1'b0;
            done1           <= 1'b0;
            rr_ptr          <= 1'b0;
            vsync_q         <= 1'b0;
            bus.addr_wr1    <= '0;
            bus.addr_wr2    <= '0;
            bus.data_wr1    <= 4'h0;
            bus.data_wr2    <= 4'h0;
            bus.wr1_en      <= 1'b0;
            bus.wr2_en      <= 1'b0;
            bus.read_pick   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.swap        <= 1'b0;
            bus.drop_count  <= 8'd0;
        end else begin
            vsync_q         <= bus.vsync;
            bus.frame_start <= 1'b0;
            bus.swap        <= 1'b0;

            // Any fall that cannot swap is a dropped frame, including one
            // that lands on the DRAW->DONE transition cycle.
            if (fall && (state != DONE) && (bus.drop_count != 8'hFF)) begin
                bus.drop_count <= bus.drop_count + 8'd1;
            end

            case (state)
                CLEAR: begin
                    if (ptr == FB_END) begin
                        // Last pair is on the ports this cycle; drawing starts next.
                        bus.wr1_en      <= 1'b0;
                        bus.wr2_en      <= 1'b0;
                        bus.frame_start <= 1'b1;
                        state           <= DRAW;
                    end else begin
                        bus.wr1_en   <= 1'b1;
                        bus.addr_wr1 <= ptr[ADDR_W-1:0];
                        bus.data_wr1 <= CLEAR_COLOR;
                        bus.wr2_en   <= 1'b1;
                        // ptr is always even, so ptr+1 is just the LSB set.
                        bus.addr_wr2 <= {ptr[ADDR_W-1:1], 1'b1};
                        bus.data_wr2 <= CLEAR_COLOR;
                        ptr          <= ptr + PTR_STEP;
                    end
                end

                DRAW: begin
                    bus.wr1_en <= write0;
                    bus.wr2_en <= write1;
                    if (write0) begin
                        bus.addr_wr1 <= bus.req0_addr;
                        bus.data_wr1 <= bus.req0_data;
                    end
                    if (write1) begin
                        bus.addr_wr2 <= bus.req1_addr;
                        bus.data_wr2 <= bus.req1_data;
                    end
                    if (conflict) begin
                        rr_ptr <= ~rr_ptr;
                    end
                    done0 <= done0 | bus.req0_done;
                    done1 <= done1 | bus.req1_done;
                    if (both_done) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    bus.wr1_en <= 1'b0;
                    bus.wr2_en <= 1'b0;
                    if (fall) begin
                        bus.read_pick <= ~bus.read_pick;
                        bus.swap      <= 1'b1;
                        done0         <= 1'b0;
                        done1         <= 1'b0;
                        ptr           <= '0;
                        state         <= CLEAR;
                    end
                end

                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule
